alu_cmd_issuer: RTL

Initiator side of the ALU datapath's command/operand interface. It accepts queued requests (command plus three operands) over a valid/ready port. It drives them one at a time onto the datapath's cmdin/din0/din1/din2 inputs, waits a fixed pipeline latency, then captures dout_high/dout_low/zero/error. Captured results are returned on a valid/ready response port. It sits between the system-side controller/testbench and the ALU datapath top.

---
 rtl/alu_cmd_issuer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Initiator side of the ALU datapath command/operand interface. Requests
//   (command + three operands) are queued in a small FIFO. Each one is issued
//   to the datapath for a single cycle, the datapath results are sampled
//   LATENCY cycles later, and they are held on a valid/ready response port.
//   Only one command is outstanding at the datapath at a time.
//
// Ports
//   clk, rst                          clock (rising edge), sync active-high reset
//   req_valid/req_ready               request handshake (ready = FIFO not full)
//   req_cmd, req_a, req_b, req_c      request command and operands
//   cmdin, din0, din1, din2           to datapath (cmdin non-zero only in ISSUE)
//   dout_low, dout_high, zero, error  from datapath (sampled in one cycle only)
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_zero, rsp_error     captured {dout_high, dout_low}, zero, error
//   busy                              FSM not idle or FIFO non-empty
//   err_count                         only with ALU_ISSUER_ERRCNT_EN defined:
//                                     saturating count of error responses
module alu_cmd_issuer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [6:0]         req_cmd,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [WIDTH-1:0]   req_c,
    output logic [6:0]         cmdin,
    output logic [WIDTH-1:0]   din0,
    output logic [WIDTH-1:0]   din1,
    output logic [WIDTH-1:0]   din2,
    input  logic [WIDTH-1:0]   dout_low,
    input  logic [WIDTH-1:0]   dout_high,
    input  logic               zero,
    input  logic               error,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_zero,
    output logic               rsp_error,
    output logic               busy
`ifdef ALU_ISSUER_ERRCNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(LATENCY + 1);
    localparam int unsigned ENT_W = 7 + 3 * WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [LAT_W-1:0]   lat_cnt;
    logic               push;
    logic               pop;
    logic [6:0]         head_cmd;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic [WIDTH-1:0]   head_c;

    // req_ready is a registered copy of !full, so a push can never collide
    // with a full FIFO, even in a cycle that also pops.
    assign push = req_valid && req_ready;
    assign pop  = (state == ISSUE);

    always_comb begin
        {head_cmd, head_a, head_b, head_c} = mem[rd_ptr];
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_cmd, req_a, req_b, req_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cmdin     <= '0;
            din0      <= '0;
            din1      <= '0;
            din2      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_error <= 1'b0;
`ifdef ALU_ISSUER_ERRCNT_EN
            err_count <= '0;
`endif
        end else begin
            count     <= count_next;
            req_ready <= (count_next != FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Next state is non-idle on every path except the two that
            // return to IDLE; those override busy with the FIFO outlook.
            busy <= 1'b1;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= ISSUE;
                        cmdin <= head_cmd;
                        din0  <= head_a;
                        din1  <= head_b;
                        din2  <= head_c;
                    end else begin
                        busy <= push;
                    end
                end
                ISSUE: begin
                    cmdin   <= '0;
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_data  <= {dout_high, dout_low};
                        rsp_zero  <= zero;
                        rsp_error <= error;
                        rsp_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef ALU_ISSUER_ERRCNT_EN
                        if (rsp_error && (err_count != 16'hFFFF)) begin
                            err_count <= err_count + 16'd1;
                        end
`endif
                        // Back-to-back issue straight from HOLD keeps the
                        // issue spacing at LATENCY+2.
                        if (count != '0) begin
                            state <= ISSUE;
                            cmdin <= head_cmd;
                            din0  <= head_a;
                            din1  <= head_b;
                            din2  <= head_c;
                        end else begin
                            state <= IDLE;
                            busy  <= push;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
